// File: rtl/opcode_entry_ctrl.sv
// Operator control: turns slide-switch nibbles and edge-detected buttons into
// processor opcodes (write, read, or multi-nibble raw entry) for datapath and display.
module opcode_entry_ctrl #(
  parameter int NIB      = 4,
  parameter int HOLD_CYC = 0,
  parameter int CNT_W    = 24
) (
  input  logic             CLK_In,
  input  logic             RST_In,
  input  logic [3:0]       User_input0,
  input  logic [3:0]       User_input1,
  output logic [4*NIB-1:0] Opcode,
  output logic             Opcode_Valid,
  output logic [3:0]       State,
  output logic [2:0]       Nib_idx
);

  localparam int OW = 4 * NIB;
  localparam logic [2:0]       LAST_IDX  = 3'(NIB - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd1,
    S_WADDR  = 4'd2,
    S_WDATA  = 4'd3,
    S_RADDR  = 4'd4,
    S_RSHOW  = 4'd5,
    S_OPENT  = 4'd8,
    S_OPSHOW = 4'd15
  } state_e;

  state_e           state_q, state_d;
  logic [OW-1:0]    opcode_q, opcode_d;
  logic             valid_q, valid_d;
  logic [2:0]       nib_idx_q, nib_idx_d;
  logic [3:0]       addr_q, addr_d;
  logic [3:0]       btn_q, btn_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       nib_q [NIB];
  logic [3:0]       nib_d [NIB];

  logic [3:0]    rise;
  logic          abort_ev, enter_ev, back_ev, blank_lvl, in_show, timeout;
  logic [OW-1:0] disp, wr_op, rd_op, entry_op;

  always_comb begin
    btn_d     = User_input1;
    rise      = User_input1 & ~btn_q;
    abort_ev  = rise[3];
    enter_ev  = (rise == 4'b0001) && (User_input1 == 4'b0001);
    back_ev   = (rise == 4'b0010) && (User_input1 == 4'b0010);
    blank_lvl = (User_input1 == 4'b0100);

    disp        = '0;
    disp[11:8]  = User_input0;
    disp[7:0]   = 8'h20;
    wr_op       = '0;
    wr_op[0]    = 1'b1;
    wr_op[4:1]  = addr_q;
    wr_op[7:5]  = 3'b001;
    wr_op[11:8] = User_input0;
    rd_op       = '0;
    rd_op[4:1]  = User_input0;

    // Final opcode includes the nibble being entered on this same edge.
    entry_op = '0;
    for (int i = 0; i < NIB; i++) begin
      entry_op[OW-1-4*i -: 4] = (nib_idx_q == 3'(i)) ? User_input0 : nib_q[i];
    end

    in_show = (state_q == S_RSHOW) || (state_q == S_OPSHOW);
    timeout = (HOLD_CYC > 0) && in_show && (cnt_q == HOLD_LAST);
    cnt_d   = in_show ? cnt_q + CNT_W'(1) : '0;
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    valid_d   = 1'b0;
    nib_idx_d = nib_idx_q;
    addr_d    = addr_q;
    nib_d     = nib_q;

    case (state_q)
      S_IDLE: begin
        opcode_d = blank_lvl ? '0 : disp;
        if (enter_ev) begin
          case (User_input0)
            4'h2:    state_d = S_WADDR;
            4'h4:    state_d = S_RADDR;
            4'h8:    state_d = S_OPENT;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_WADDR: begin
        opcode_d = disp;
        if (enter_ev) begin
          addr_d  = User_input0;
          state_d = S_WDATA;
        end else if (back_ev) begin
          state_d = S_IDLE;
        end
      end
      S_WDATA: begin
        opcode_d = disp;
        if (enter_ev) begin
          opcode_d = wr_op;
          valid_d  = 1'b1;
          state_d  = S_IDLE;
        end else if (back_ev) begin
          state_d = S_WADDR;
        end
      end
      S_RADDR: begin
        opcode_d = disp;
        if (enter_ev) begin
          addr_d   = User_input0;
          opcode_d = rd_op;
          valid_d  = 1'b1;
          state_d  = S_RSHOW;
        end else if (back_ev) begin
          state_d = S_IDLE;
        end
      end
      S_RSHOW, S_OPSHOW: begin
        if (enter_ev || timeout) state_d = S_IDLE;
      end
      S_OPENT: begin
        opcode_d = disp;
        if (enter_ev) begin
          for (int i = 0; i < NIB; i++) begin
            if (nib_idx_q == 3'(i)) nib_d[i] = User_input0;
          end
          if (nib_idx_q == LAST_IDX) begin
            opcode_d  = entry_op;
            valid_d   = 1'b1;
            nib_idx_d = '0;
            state_d   = S_OPSHOW;
          end else begin
            nib_idx_d = nib_idx_q + 3'd1;
          end
        end else if (back_ev) begin
          if (nib_idx_q == '0) state_d = S_IDLE;
          else nib_idx_d = nib_idx_q - 3'd1;
        end
      end
      default: begin
        opcode_d  = disp;
        nib_idx_d = '0;
        state_d   = S_IDLE;
      end
    endcase

    // Abort wins over whatever the state decided this cycle.
    if (abort_ev) begin
      state_d   = S_IDLE;
      nib_idx_d = '0;
      opcode_d  = disp;
      valid_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK_In) begin
    if (RST_In) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      valid_q   <= 1'b0;
      nib_idx_q <= '0;
      addr_q    <= '0;
      btn_q     <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < NIB; i++) nib_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      valid_q   <= valid_d;
      nib_idx_q <= nib_idx_d;
      addr_q    <= addr_d;
      btn_q     <= btn_d;
      cnt_q     <= cnt_d;
      for (int i = 0; i < NIB; i++) nib_q[i] <= nib_d[i];
    end
  end

  assign Opcode       = opcode_q;
  assign Opcode_Valid = valid_q;
  assign State        = state_q;
  assign Nib_idx      = nib_idx_q;

endmodule

// File: tb/tb_opcode_entry_ctrl.sv
// Bench for opcode_entry_ctrl: two instances (no timeout / 5-cycle timeout) driven
// in lockstep, each compared every cycle against its own behavioural model.
module tb_opcode_entry_ctrl;

  localparam int NIBM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sw, btn;
  logic [15:0] op0, op5;
  logic        v0, v5;
  logic [3:0]  st0, st5;
  logic [2:0]  ni0, ni5;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  opcode_entry_ctrl #(.NIB(4), .HOLD_CYC(0), .CNT_W(24)) dut0 (
    .CLK_In(clk), .RST_In(rst), .User_input0(sw), .User_input1(btn),
    .Opcode(op0), .Opcode_Valid(v0), .State(st0), .Nib_idx(ni0)
  );

  opcode_entry_ctrl #(.NIB(4), .HOLD_CYC(5), .CNT_W(8)) dut5 (
    .CLK_In(clk), .RST_In(rst), .User_input0(sw), .User_input1(btn),
    .Opcode(op5), .Opcode_Valid(v5), .State(st5), .Nib_idx(ni5)
  );

  typedef struct {
    int st;
    int idx;
    int addr;
    int nib [8];
    int op;
    bit vld;
    int prev;
    int age;
  } mdl_t;

  mdl_t m0, m5;

  // Operator-level model: one call per clock edge with the inputs seen at that edge.
  function automatic mdl_t mstep(mdl_t m, int s, int b, bit r, int hold);
    int  rise, disp, val;
    bit  abort, enter, back, blank, show, expired;
    if (r) begin
      m.st = 1; m.op = 0; m.vld = 0; m.idx = 0; m.addr = 0; m.prev = 0; m.age = 0;
      for (int i = 0; i < 8; i++) m.nib[i] = 0;
      return m;
    end
    rise    = b & ~m.prev & 15;
    m.prev  = b;
    abort   = (rise & 8) != 0;
    enter   = (rise == 1) && (b == 1);
    back    = (rise == 2) && (b == 2);
    blank   = (b == 4);
    disp    = (s << 8) | 'h20;
    show    = (m.st == 5) || (m.st == 15);
    expired = (hold > 0) && show && (m.age == hold - 1);
    m.age   = show ? m.age + 1 : 0;
    m.vld   = 0;
    if (abort) begin
      m.st = 1; m.idx = 0; m.op = disp;
      return m;
    end
    case (m.st)
      1: begin
        m.op = blank ? 0 : disp;
        if (enter && (s == 2 || s == 4 || s == 8)) m.st = s;
      end
      2: begin
        m.op = disp;
        if (enter) begin m.addr = s; m.st = 3; end
        else if (back) m.st = 1;
      end
      3: begin
        m.op = disp;
        if (enter) begin
          m.op = 1 + m.addr * 2 + 'h20 + s * 256; m.vld = 1; m.st = 1;
        end else if (back) m.st = 2;
      end
      4: begin
        m.op = disp;
        if (enter) begin m.addr = s; m.op = s * 2; m.vld = 1; m.st = 5; end
        else if (back) m.st = 1;
      end
      5, 15: if (enter || expired) m.st = 1;
      8: begin
        m.op = disp;
        if (enter) begin
          m.nib[m.idx] = s;
          if (m.idx < NIBM - 1) m.idx++;
          else begin
            val = 0;
            for (int i = 0; i < NIBM; i++) val = val * 16 + m.nib[i];
            m.op = val; m.vld = 1; m.st = 15; m.idx = 0;
          end
        end else if (back) begin
          if (m.idx > 0) m.idx--;
          else m.st = 1;
        end
      end
      default: m.st = 1;
    endcase
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] s, input logic [3:0] b, input logic r);
    sw  = s;
    btn = b;
    rst = r;
    @(posedge clk);
    m0 = mstep(m0, int'(s), int'(b), r, 0);
    m5 = mstep(m5, int'(s), int'(b), r, 5);
    #1;
    check("state0", 32'(st0), m0.st);
    check("opcode0", 32'(op0), m0.op);
    check("valid0", 32'(v0), 32'(m0.vld));
    check("nibidx0", 32'(ni0), m0.idx);
    check("state5", 32'(st5), m5.st);
    check("opcode5", 32'(op5), m5.op);
    check("valid5", 32'(v5), 32'(m5.vld));
    check("nibidx5", 32'(ni5), m5.idx);
  endtask

  task automatic press(input logic [3:0] s, input logic [3:0] b);
    applyStimulus(s, b, 1'b0);
    applyStimulus(s, 4'b0000, 1'b0);
  endtask

  initial begin
    logic [3:0] b, s;
    sw = '0; btn = '0; rst = 1'b1;
    applyStimulus(4'h0, 4'h0, 1'b1);
    applyStimulus(4'h0, 4'h0, 1'b1);
    check("rst_state", 32'(st0), 32'd1);
    check("rst_opcode", 32'(op0), 32'd0);
    check("rst_nibidx", 32'(ni5), 32'd0);

    // Write transaction
    press(4'h2, 4'b0001);
    press(4'h5, 4'b0001);
    check("wr_state", 32'(st0), 32'd3);
    applyStimulus(4'hA, 4'b0001, 1'b0);
    check("wr_opcode", 32'(op0), 32'h0A2B);
    check("wr_valid", 32'(v0), 32'd1);
    applyStimulus(4'hA, 4'b0000, 1'b0);
    check("wr_valid_drop", 32'(v0), 32'd0);

    // Held Enter gives one event, then read
    for (int i = 0; i < 10; i++) applyStimulus(4'h4, 4'b0001, 1'b0);
    check("hold_state", 32'(st0), 32'd4);
    applyStimulus(4'h3, 4'b0000, 1'b0);
    applyStimulus(4'h3, 4'b0001, 1'b0);
    check("rd_opcode", 32'(op0), 32'h0006);
    check("rd_valid", 32'(v0), 32'd1);
    applyStimulus(4'h3, 4'b0000, 1'b0);
    check("rd_hold", 32'(op0), 32'h0006);
    press(4'h0, 4'b0001);

    // Op entry with undo
    press(4'h8, 4'b0001);
    press(4'h1, 4'b0001);
    press(4'h2, 4'b0001);
    check("ent_idx2", 32'(ni0), 32'd2);
    press(4'h0, 4'b0010);
    check("ent_back", 32'(ni0), 32'd1);
    press(4'h7, 4'b0001);
    press(4'h3, 4'b0001);
    applyStimulus(4'h4, 4'b0001, 1'b0);
    check("ent_opcode", 32'(op0), 32'h1734);
    check("ent_state", 32'(st0), 32'd15);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(4'h0, 4'b0000, 1'b0);
      check("to_state5", 32'(st5), (i >= 5) ? 32'd1 : 32'd15);
      check("to_state0", 32'(st0), 32'd15);
    end
    press(4'h0, 4'b0001);

    // Abort together with Enter
    press(4'h2, 4'b0001);
    press(4'h5, 4'b0001);
    applyStimulus(4'h6, 4'b1001, 1'b0);
    check("abort_wd_op", 32'(op0), 32'h0620);
    check("abort_wd_vld", 32'(v0), 32'd0);
    applyStimulus(4'h6, 4'b0000, 1'b0);
    press(4'h8, 4'b0001);
    press(4'h1, 4'b0001);
    press(4'h2, 4'b0001);
    applyStimulus(4'h9, 4'b1001, 1'b0);
    check("abort_oe_st", 32'(st0), 32'd1);
    check("abort_oe_idx", 32'(ni0), 32'd0);
    applyStimulus(4'h9, 4'b0000, 1'b0);

    // Reset mid-entry, then Blank level
    press(4'h8, 4'b0001);
    press(4'h1, 4'b0001);
    press(4'h2, 4'b0001);
    applyStimulus(4'h3, 4'b0000, 1'b1);
    check("mid_rst_idx", 32'(ni0), 32'd0);
    check("mid_rst_op", 32'(op0), 32'd0);
    applyStimulus(4'h3, 4'b0000, 1'b0);
    check("disp_op", 32'(op0), 32'h0320);
    for (int i = 0; i < 3; i++) applyStimulus(4'h3, 4'b0100, 1'b0);
    check("blank_op", 32'(op0), 32'd0);
    applyStimulus(4'h3, 4'b0000, 1'b0);
    check("unblank_op", 32'(op0), 32'h0320);

    // Randomised operator activity
    b = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: s = 4'(1 << $urandom_range(1, 3));
        default: s = 4'($urandom_range(0, 15));
      endcase
      case ($urandom_range(0, 11))
        0, 1, 2: b = 4'b0001;
        3, 4:    b = 4'b0010;
        5:       b = 4'b0100;
        6:       b = ($urandom_range(0, 3) == 0) ? 4'b1000 : 4'b1001;
        7:       b = 4'($urandom_range(0, 15));
        8, 9:    b = b;
        default: b = 4'b0000;
      endcase
      applyStimulus(s, b, ($urandom_range(0, 299) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
